// File: rtl/affine_had_if.sv
// Hadamard-cost handshake between affine_control (master) and affine_had_accum (slave).
// AFFINE_HAD_EARLY_TERM_EN adds cost_bound / early_term.
interface affine_had_if #(
  parameter int SATD_W = 12,
  parameter int COST_W = 16
);
  logic              start;
  logic [5:0]        num_of_sub_blk;
  logic              en;
  logic              export_data_had;
  logic [SATD_W-1:0] sub_satd;
  logic [COST_W-1:0] had_4_param;
  logic [COST_W-1:0] had_6_param;
  logic              had_valid;
  logic              busy;
`ifdef AFFINE_HAD_EARLY_TERM_EN
  logic [COST_W-1:0] cost_bound;
  logic              early_term;

  modport master (
    output start, num_of_sub_blk, en, export_data_had, sub_satd, cost_bound,
    input  had_4_param, had_6_param, had_valid, busy, early_term
  );
  modport slave (
    input  start, num_of_sub_blk, en, export_data_had, sub_satd, cost_bound,
    output had_4_param, had_6_param, had_valid, busy, early_term
  );
`else
  modport master (
    output start, num_of_sub_blk, en, export_data_had, sub_satd,
    input  had_4_param, had_6_param, had_valid, busy
  );
  modport slave (
    input  start, num_of_sub_blk, en, export_data_had, sub_satd,
    output had_4_param, had_6_param, had_valid, busy
  );
`endif
endinterface

// File: rtl/affine_had_accum.sv
// Accumulates per-sub-block SATD over a 4-param pass then a 6-param pass.
// Optional feature: AFFINE_HAD_EARLY_TERM_EN (cost_bound early termination).
module affine_had_accum #(
  parameter int SATD_W = 12,
  parameter int COST_W = 16,
  parameter int ACC_W  = 18
) (
  input logic         clk,
  input logic         rst_n,
  affine_had_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC4, ACC6} state_t;

  state_t            state, state_next;
  logic [ACC_W-1:0]  acc, sum;
  logic [6:0]        cnt, n_blk;
  logic              acc_take, last_take, add_ok;
  logic [COST_W-1:0] pass_result;
  logic [COST_W-1:0] had4, had6;
  logic              valid;

  function automatic logic [COST_W-1:0] sat(input logic [ACC_W-1:0] x);
    return (x > ACC_W'({COST_W{1'b1}})) ? '1 : x[COST_W-1:0];
  endfunction

  assign acc_take  = bus.en & bus.export_data_had & (state != IDLE);
  assign sum       = acc + ACC_W'(bus.sub_satd);
  assign last_take = acc_take & ((cnt + 7'd1) == n_blk);

`ifdef AFFINE_HAD_EARLY_TERM_EN
  logic [COST_W-1:0] bound;
  logic              pass_term, term_now, early_term_q;

  assign term_now    = acc_take & ~pass_term & (sum > ACC_W'(bound));
  assign add_ok      = ~(pass_term | term_now);
  assign pass_result = add_ok ? sat(sum) : '1;
  assign bus.early_term = early_term_q;

  // Termination only freezes the sum; cnt keeps advancing so timing is unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bound        <= '0;
      pass_term    <= 1'b0;
      early_term_q <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        bound        <= bus.cost_bound;
        pass_term    <= 1'b0;
        early_term_q <= 1'b0;
      end
    end else if (acc_take) begin
      pass_term <= last_take ? 1'b0 : (pass_term | term_now);
      if (last_take)
        early_term_q <= early_term_q | pass_term | term_now;
    end
  end
`else
  assign add_ok      = 1'b1;
  assign pass_result = sat(sum);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = ACC4;
      ACC4:    if (last_take) state_next = ACC6;
      ACC6:    if (last_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      n_blk <= '0;
      had4  <= '0;
      had6  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          n_blk <= (bus.num_of_sub_blk == '0) ? 7'd64 : {1'b0, bus.num_of_sub_blk};
          acc   <= '0;
          cnt   <= '0;
        end
      end else if (acc_take) begin
        if (last_take) begin
          acc <= '0;
          cnt <= '0;
          if (state == ACC4) begin
            had4 <= pass_result;
          end else begin
            had6  <= pass_result;
            valid <= 1'b1;
          end
        end else begin
          cnt <= cnt + 7'd1;
          if (add_ok) acc <= sum;
        end
      end
    end
  end

  assign bus.had_4_param = had4;
  assign bus.had_6_param = had6;
  assign bus.had_valid   = valid;
  assign bus.busy        = (state != IDLE);

endmodule
